// File: rtl/graphics_rect_drawer_pkg.sv
// Shared encodings for the VGA graphics path: draw modes, drawer FSM states
// and the fixed colours used by erase/flash.
package graphics_pkg;

  typedef enum logic [1:0] {
    MODE_FILL    = 2'b00,
    MODE_OUTLINE = 2'b01,
    MODE_ERASE   = 2'b10,
    MODE_FLASH   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DRAW = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Wide constants; users slice the low COLOUR_W bits.
  localparam logic [31:0] COLOUR_BLACK = 32'h0000_0000;
  localparam logic [31:0] COLOUR_WHITE = 32'hFFFF_FFFF;

endpackage

// File: rtl/graphics_rect_drawer_if.sv
// Control handshake and pixel output bundle between the graphics control FSM,
// the rectangle drawer and the VGA adapter.
interface graphics_rect_drawer_if
  import graphics_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3
);

  logic                start;
  logic                abort;
  logic [X_W-1:0]      x_in;
  logic [Y_W-1:0]      y_in;
  logic [COLOUR_W-1:0] colour_in;
  mode_e               mode;

  logic                busy;
  logic                done;
  logic                plot;
  logic [X_W-1:0]      x_out;
  logic [Y_W-1:0]      y_out;
  logic [COLOUR_W-1:0] colour_out;

  modport master (
    output start, abort, x_in, y_in, colour_in, mode,
    input  busy, done, plot, x_out, y_out, colour_out
  );

  modport slave (
    input  start, abort, x_in, y_in, colour_in, mode,
    output busy, done, plot, x_out, y_out, colour_out
  );

endinterface

// File: rtl/graphics_rect_drawer_raster_counter.sv
// Two-dimensional scan counter: cx is the fast axis, cy advances when cx wraps.
// Flags the final position and positions on the window border.
module graphics_raster_counter #(
  parameter int BOX_W = 8,
  parameter int BOX_H = 8,
  parameter int CX_W  = (BOX_W > 1) ? $clog2(BOX_W) : 1,
  parameter int CY_W  = (BOX_H > 1) ? $clog2(BOX_H) : 1
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            clear,
  input  logic            enable,
  output logic [CX_W-1:0] cx,
  output logic [CY_W-1:0] cy,
  output logic            last,
  output logic            border
);

  localparam logic [CX_W-1:0] CX_LAST = CX_W'(BOX_W - 1);
  localparam logic [CY_W-1:0] CY_LAST = CY_W'(BOX_H - 1);

  logic cx_last;
  logic cy_last;

  assign cx_last = (cx == CX_LAST);
  assign cy_last = (cy == CY_LAST);
  assign last    = cx_last && cy_last;
  // A 1-wide or 1-tall window makes every position a border position.
  assign border  = (cx == '0) || cx_last || (cy == '0) || cy_last;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cx <= '0;
      cy <= '0;
    end else if (clear) begin
      cx <= '0;
      cy <= '0;
    end else if (enable) begin
      if (cx_last) begin
        cx <= '0;
        cy <= cy_last ? '0 : cy + 1'b1;
      end else begin
        cx <= cx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/graphics_rect_drawer.sv
// Rectangle raster engine: walks a BOX_W x BOX_H window one pixel per clock,
// clipping to the screen and masking interior pixels in outline mode.
module graphics_rect_drawer
  import graphics_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int BOX_W    = 8,
  parameter int BOX_H    = 8,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                  clock,
  input  logic                  resetn,
  graphics_rect_drawer_if.slave bus
);

  localparam int CX_W = (BOX_W > 1) ? $clog2(BOX_W) : 1;
  localparam int CY_W = (BOX_H > 1) ? $clog2(BOX_H) : 1;

  localparam logic [X_W:0] SCR_X = (X_W + 1)'(SCREEN_W);
  localparam logic [Y_W:0] SCR_Y = (Y_W + 1)'(SCREEN_H);

  state_e              state;
  state_e              state_nxt;
  logic [X_W-1:0]      xb;
  logic [Y_W-1:0]      yb;
  mode_e               mode_r;
  logic [COLOUR_W-1:0] colour_r;

  logic [CX_W-1:0]     cx;
  logic [CY_W-1:0]     cy;
  logic                last;
  logic                border;

  logic                accept;
  logic                drawing;
  logic [X_W:0]        x_sum;
  logic [Y_W:0]        y_sum;
  logic                on_screen;

  function automatic logic [COLOUR_W-1:0] eff_colour(input mode_e m,
                                                     input logic [COLOUR_W-1:0] c);
    case (m)
      MODE_ERASE: return COLOUR_BLACK[COLOUR_W-1:0];
      MODE_FLASH: return COLOUR_WHITE[COLOUR_W-1:0];
      default:    return c;
    endcase
  endfunction

  assign accept  = (state == ST_IDLE) && bus.start;
  assign drawing = (state == ST_DRAW);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.start) state_nxt = ST_DRAW;
      ST_DRAW: if (bus.abort || last) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Base, mode and colour are captured only on acceptance, so start while busy
  // never disturbs an in-flight draw.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      xb       <= '0;
      yb       <= '0;
      mode_r   <= MODE_FILL;
      colour_r <= '0;
    end else if (accept) begin
      xb       <= bus.x_in;
      yb       <= bus.y_in;
      mode_r   <= bus.mode;
      colour_r <= eff_colour(bus.mode, bus.colour_in);
    end
  end

  graphics_raster_counter #(
    .BOX_W (BOX_W),
    .BOX_H (BOX_H),
    .CX_W  (CX_W),
    .CY_W  (CY_W)
  ) u_counter (
    .clock  (clock),
    .resetn (resetn),
    .clear  (accept),
    .enable (drawing),
    .cx     (cx),
    .cy     (cy),
    .last   (last),
    .border (border)
  );

  // One extra bit so an address past the top of the bus reads as off-screen.
  assign x_sum     = {1'b0, xb} + {{(X_W + 1 - CX_W){1'b0}}, cx};
  assign y_sum     = {1'b0, yb} + {{(Y_W + 1 - CY_W){1'b0}}, cy};
  assign on_screen = (x_sum < SCR_X) && (y_sum < SCR_Y);

  assign bus.busy       = drawing;
  assign bus.done       = (state == ST_DONE);
  assign bus.plot       = drawing && on_screen && ((mode_r != MODE_OUTLINE) || border);
  assign bus.x_out      = x_sum[X_W-1:0];
  assign bus.y_out      = y_sum[Y_W-1:0];
  assign bus.colour_out = colour_r;

endmodule
